// File: rtl/fp_adder_seq.sv
// Sequential FP adder/subtractor: value = (-1)^sign * 0.frac * 2^exp, unbiased exponent.
// Alignment and normalisation shift one bit per clock; valid/ready on both sides.
module fp_adder_seq #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sub,
  input  logic              sign_a,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [FRAC_W-1:0] frac_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              ovf,
  output logic              unf
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // ALIGN | shifting the smaller fraction right until exponents match
  // ADD   | magnitude add or subtract
  // NORM  | renormalising the sum, detecting overflow/underflow
  // DONE  | result presented until out_ready
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t state_q, state_d;

  logic              sign_big, sign_small;
  logic [EXP_W-1:0]  exp_r, diff;
  logic [FRAC_W-1:0] frac_big, frac_small;
  logic [FRAC_W:0]   sum;

  logic sign_b_eff, a_is_big, align_done, norm_done;

  assign sign_b_eff = sign_b ^ sub;
  assign a_is_big   = {exp_a, frac_a} >= {exp_b, frac_b};
  assign align_done = (diff == '0) || (frac_small == '0);
  assign norm_done  = sum[FRAC_W] || (sum == '0) || sum[FRAC_W-1] || (exp_r == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_ALIGN;
      end
      S_ALIGN: if (align_done) state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  if (norm_done) state_d = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_r      <= '0;
      diff       <= '0;
      frac_big   <= '0;
      frac_small <= '0;
      sum        <= '0;
      sign_out   <= 1'b0;
      exp_out    <= '0;
      frac_out   <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Ties go to a so that a-a yields a positive zero path through big=a.
            if (a_is_big) begin
              sign_big   <= sign_a;
              sign_small <= sign_b_eff;
              exp_r      <= exp_a;
              frac_big   <= frac_a;
              frac_small <= frac_b;
              diff       <= exp_a - exp_b;
            end else begin
              sign_big   <= sign_b_eff;
              sign_small <= sign_a;
              exp_r      <= exp_b;
              frac_big   <= frac_b;
              frac_small <= frac_a;
              diff       <= exp_b - exp_a;
            end
          end
        end
        S_ALIGN: begin
          if (!align_done) begin
            frac_small <= frac_small >> 1;
            diff       <= diff - EXP_W'(1);
          end
        end
        S_ADD: begin
          if (sign_big == sign_small) sum <= {1'b0, frac_big} + {1'b0, frac_small};
          else                        sum <= {1'b0, frac_big} - {1'b0, frac_small};
        end
        S_NORM: begin
          if (sum[FRAC_W]) begin
            sign_out <= sign_big;
            unf      <= 1'b0;
            if (&exp_r) begin
              ovf      <= 1'b1;
              exp_out  <= '1;
              frac_out <= '1;
            end else begin
              ovf      <= 1'b0;
              exp_out  <= exp_r + EXP_W'(1);
              frac_out <= sum[FRAC_W:1];
            end
          end else if (sum == '0) begin
            sign_out <= 1'b0;
            exp_out  <= '0;
            frac_out <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
          end else if (sum[FRAC_W-1]) begin
            sign_out <= sign_big;
            exp_out  <= exp_r;
            frac_out <= sum[FRAC_W-1:0];
            ovf      <= 1'b0;
            unf      <= 1'b0;
          end else if (exp_r == '0) begin
            sign_out <= 1'b0;
            exp_out  <= '0;
            frac_out <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b1;
          end else begin
            sum   <= sum << 1;
            exp_r <= exp_r - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
